core5_cpu_oci_dct_packer: RTL

//  Upstream producer of the OCI direct-control-transfer (DCT) trace fields dct_buffer/dct_count.

---
 rtl/core5_oci_pkg.sv | 18 +
 rtl/core5_oci_msg_slot.sv | 42 ++++
 rtl/core5_cpu_oci_dct_packer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/core5_oci_pkg.sv
// Shared widths, DCT code values, packer states and the message record.
package core5_oci_pkg;
  localparam int DCT_DEPTH = 15;
  localparam int CODE_W    = 2;
  localparam int CNT_W     = 4;
  localparam int BUF_W     = DCT_DEPTH * CODE_W;

  localparam logic [CODE_W-1:0] DCT_TAKEN    = 2'b10;
  localparam logic [CODE_W-1:0] DCT_NOTTAKEN = 2'b01;
  localparam logic [CNT_W-1:0]  CNT_FULL     = CNT_W'(DCT_DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_WAIT} state_t;

  typedef struct packed {
    logic [BUF_W-1:0] buffer;
    logic [CNT_W-1:0] count;
  } dct_msg_t;
endpackage

// File: rtl/core5_oci_msg_slot.sv
// One-entry valid/ready holding register for a packed DCT message.
// The caller only asserts load when the slot is free (empty or draining).
module core5_oci_msg_slot
  import core5_oci_pkg::*;
(
  input  logic     clk,
  input  logic     jrst_n,
  input  logic     load,
  input  dct_msg_t load_msg,
  input  logic     ready,
  output logic     valid,
  output dct_msg_t msg
);
  logic     valid_q, valid_d;
  dct_msg_t msg_q, msg_d;

  // Reload wins over the handshake so back-to-back messages need no bubble.
  always_comb begin
    valid_d = valid_q;
    msg_d   = msg_q;
    if (load) begin
      valid_d = 1'b1;
      msg_d   = load_msg;
    end else if (ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot register; reset discards any held message.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      valid_q <= 1'b0;
      msg_q   <= '0;
    end else begin
      valid_q <= valid_d;
      msg_q   <= msg_d;
    end
  end

  assign valid = valid_q;
  assign msg   = msg_q;
endmodule

// File: rtl/core5_cpu_oci_dct_packer.sv
// Packs retired 2-bit branch codes into a 15-entry buffer and hands full or
// flushed buffers to the trace FIFO through a one-entry message slot.
module core5_cpu_oci_dct_packer
  import core5_oci_pkg::*;
(
  input  logic              clk,
  input  logic              jrst_n,
  input  logic              trc_on,
  input  logic              dct_valid,
  input  logic [CODE_W-1:0] dct_code,
  input  logic              dct_flush,
  input  logic              msg_ready,
  output logic              msg_valid,
  output logic [BUF_W-1:0]  msg_buffer,
  output logic [CNT_W-1:0]  msg_count,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              pending,
  output logic              overflow,
  input  logic              overflow_clr
);
  state_t           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d, nbuf, app_buf;
  logic [CNT_W-1:0] cnt_q, cnt_d, ncnt, app_cnt;
  logic             trc_q, overflow_q, overflow_d, ovf_set;
  logic             acc, close, slot_free, slot_load, slot_valid;
  dct_msg_t         slot_in, slot_msg;

  assign acc       = dct_valid && trc_on;
  assign close     = dct_flush || (trc_q && !trc_on);
  assign slot_free = !slot_valid || msg_ready;
  assign app_buf   = {buf_q[BUF_W-CODE_W-1:0], dct_code};
  assign app_cnt   = cnt_q + 1'b1;

  // Packer FSM: append, close into the slot, or park in S_WAIT while it is busy.
  // The buffer is zeroed on every close so an append from empty yields {0, code}.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    nbuf      = buf_q;
    ncnt      = cnt_q;
    ovf_set   = 1'b0;
    slot_load = 1'b0;
    slot_in   = '{buffer: buf_q, count: cnt_q};
    case (state_q)
      S_EMPTY, S_FILL: begin
        if (acc && cnt_q == CNT_FULL) begin
          if (slot_free) begin
            // Ship the full buffer; the new code opens a fresh one. A
            // simultaneous close must then wait for the slot just loaded.
            slot_load = 1'b1;
            buf_d     = {{(BUF_W-CODE_W){1'b0}}, dct_code};
            cnt_d     = CNT_W'(1);
            state_d   = close ? S_WAIT : S_FILL;
          end else begin
            ovf_set = 1'b1;
            state_d = S_WAIT;
          end
        end else begin
          if (acc) begin
            nbuf = app_buf;
            ncnt = app_cnt;
          end
          buf_d = nbuf;
          cnt_d = ncnt;
          if (close && ncnt != '0) begin
            if (slot_free) begin
              slot_load = 1'b1;
              slot_in   = '{buffer: nbuf, count: ncnt};
              buf_d     = '0;
              cnt_d     = '0;
              state_d   = S_EMPTY;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = (ncnt == '0) ? S_EMPTY : S_FILL;
          end
        end
      end
      S_WAIT: begin
        // Buffer is frozen; codes are dropped and extra flushes merge.
        ovf_set = acc;
        if (slot_free) begin
          slot_load = 1'b1;
          buf_d     = '0;
          cnt_d     = '0;
          state_d   = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle.
  always_comb overflow_d = ovf_set || (overflow_q && !overflow_clr);

  // Packer state registers.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state_q    <= S_EMPTY;
      buf_q      <= '0;
      cnt_q      <= '0;
      trc_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      trc_q      <= trc_on;
      overflow_q <= overflow_d;
    end
  end

  core5_oci_msg_slot u_slot (
    .clk      (clk),
    .jrst_n   (jrst_n),
    .load     (slot_load),
    .load_msg (slot_in),
    .ready    (msg_ready),
    .valid    (slot_valid),
    .msg      (slot_msg)
  );

  assign msg_valid  = slot_valid;
  assign msg_buffer = slot_msg.buffer;
  assign msg_count  = slot_msg.count;
  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign pending    = (state_q == S_WAIT);
  assign overflow   = overflow_q;
endmodule
